// File: rtl/fifo_rr_controller_if.sv
// Bus bundle for fifo_rr_controller: write requesters, read consumer,
// shared fifo port and occupancy. The controller uses the slave modport;
// the surrounding system (producers, consumer, fifo) uses the master modport.
interface fifo_rr_controller_if #(
    parameter int word_size = 32,
    parameter int NUM_REQ   = 4,
    parameter int COUNT_W   = 5
);
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*word_size-1:0] req_data;
    logic [NUM_REQ-1:0]           grant;
    logic                         rd_req;
    logic                         rd_valid;
    logic [word_size-1:0]         rd_data;
    logic                         fifo_write_enable;
    logic [word_size-1:0]         fifo_data_in;
    logic                         fifo_read_enable;
    logic [word_size-1:0]         fifo_data_out;
    logic [COUNT_W-1:0]           count;

    modport slave (
        input  req, req_data, rd_req, fifo_data_out,
        output grant, rd_valid, rd_data, fifo_write_enable, fifo_data_in,
               fifo_read_enable, count
    );

    modport master (
        output req, req_data, rd_req, fifo_data_out,
        input  grant, rd_valid, rd_data, fifo_write_enable, fifo_data_in,
               fifo_read_enable, count
    );
endinterface

// File: rtl/fifo_rr_controller.sv
// Round-robin write arbiter and read sequencer in front of one shared fifo.
// Occupancy is tracked locally so the fifo is never written when full or
// read when empty. The fifo registers data_out at the edge where it samples
// read_enable, so read data is captured one edge after that.
module fifo_rr_controller #(
    parameter int word_size  = 32,
    parameter int fifo_depth = 21,
    parameter int NUM_REQ    = 4,
    parameter int COUNT_W    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    fifo_rr_controller_if.slave   bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {RD_IDLE, RD_WAIT} rd_state_e;

    logic [NUM_REQ-1:0]   grant_q;
    logic                 fifo_we_q;
    logic [word_size-1:0] fifo_din_q;
    logic [PTR_W-1:0]     rr_ptr_q;
    logic                 fifo_re_q;
    logic                 cap_q;
    logic                 rd_valid_q;
    logic [word_size-1:0] rd_data_q;
    logic [COUNT_W-1:0]   count_q;
    rd_state_e            state_q;

    logic [NUM_REQ-1:0]   eligible_d;
    logic                 wr_admit_d;
    logic                 rd_admit_d;
    logic [PTR_W-1:0]     winner_d;
    logic [word_size-1:0] wr_word_d;
    logic [COUNT_W-1:0]   count_d;

    // Arbitration: mask last cycle's winner, then search round-robin from rr_ptr+1.
    always_comb begin
        int  idx;
        logic found;
        idx        = 0;
        found      = 1'b0;
        winner_d   = rr_ptr_q;
        eligible_d = bus.req & ~grant_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && eligible_d[idx]) begin
                winner_d = PTR_W'(idx);
                found    = 1'b1;
            end
        end
        wr_admit_d = found && (count_q < COUNT_W'(fifo_depth));
        rd_admit_d = bus.rd_req && (count_q != '0);
        wr_word_d  = bus.req_data[int'(winner_d)*word_size +: word_size];
    end

    // Occupancy next value; a simultaneous write and read cancel out.
    always_comb begin
        count_d = count_q;
        case ({wr_admit_d, rd_admit_d})
            2'b10:   count_d = count_q + COUNT_W'(1);
            2'b01:   count_d = count_q - COUNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Write port: register the winner's word, one-hot grant and new round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q    <= '0;
            fifo_we_q  <= 1'b0;
            fifo_din_q <= '0;
            rr_ptr_q   <= PTR_W'(NUM_REQ - 1);
        end else if (wr_admit_d) begin
            grant_q    <= NUM_REQ'(1) << winner_d;
            fifo_we_q  <= 1'b1;
            fifo_din_q <= wr_word_d;
            rr_ptr_q   <= winner_d;
        end else begin
            grant_q    <= '0;
            fifo_we_q  <= 1'b0;
        end
    end

    // Read FSM: issue reads, then capture fifo data_out one edge after the fifo updates it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RD_IDLE;
            fifo_re_q  <= 1'b0;
            cap_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            fifo_re_q  <= rd_admit_d;
            cap_q      <= fifo_re_q;
            rd_valid_q <= 1'b0;
            case (state_q)
                RD_IDLE: begin
                    if (rd_admit_d) state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (cap_q) begin
                        rd_data_q  <= bus.fifo_data_out;
                        rd_valid_q <= 1'b1;
                    end
                    if (!rd_admit_d && !fifo_re_q) state_q <= RD_IDLE;
                end
                default: state_q <= RD_IDLE;
            endcase
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign bus.grant             = grant_q;
    assign bus.fifo_write_enable = fifo_we_q;
    assign bus.fifo_data_in      = fifo_din_q;
    assign bus.fifo_read_enable  = fifo_re_q;
    assign bus.rd_valid          = rd_valid_q;
    assign bus.rd_data           = rd_data_q;
    assign bus.count             = count_q;
endmodule

// File: tb/tb_fifo_rr_controller.sv
// Bench for fifo_rr_controller: directed scenarios followed by random traffic,
// checked against a queue-based reference model of the arbiter, occupancy and
// read return path. A small behavioural fifo stands in for the shared fifo.
module tb_fifo_rr_controller;
    localparam int W  = 32;
    localparam int D  = 21;
    localparam int N  = 4;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_rr_controller_if #(.word_size(W), .NUM_REQ(N), .COUNT_W(CW)) bus ();

    fifo_rr_controller #(.word_size(W), .fifo_depth(D), .NUM_REQ(N), .COUNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Shared fifo stand-in: data_out registered at the edge that samples read_enable.
    logic [W-1:0] fifo_mem[$];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_mem.delete();
            bus.fifo_data_out <= '0;
        end else begin
            if (bus.fifo_read_enable && fifo_mem.size() > 0)
                bus.fifo_data_out <= fifo_mem.pop_front();
            if (bus.fifo_write_enable)
                fifo_mem.push_back(bus.fifo_data_in);
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int           m_last;
    logic [N-1:0] m_grant;
    int           m_cnt;
    logic [W-1:0] m_q[$];
    bit           m_we;
    logic [W-1:0] m_din;
    bit           m_re;
    logic [W-1:0] m_ad;
    bit           m_bv;
    logic [W-1:0] m_bd;
    bit           m_rv;
    logic [W-1:0] m_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last  = N - 1;
        m_grant = '0;
        m_cnt   = 0;
        m_q.delete();
        m_we  = 0; m_din = '0;
        m_re  = 0; m_ad  = '0;
        m_bv  = 0; m_bd  = '0;
        m_rv  = 0; m_rd  = '0;
    endtask

    // One clock of the specified behaviour, evaluated on the inputs present before the edge.
    task automatic model_step();
        logic [N-1:0] elig;
        bit wr, rd;
        int w;
        elig = bus.req & ~m_grant;
        wr   = (elig != '0) && (m_cnt < D);
        rd   = bus.rd_req && (m_cnt > 0);
        m_rv = m_bv;
        if (m_bv) m_rd = m_bd;
        m_bv = m_re;
        m_bd = m_ad;
        m_re = rd;
        if (rd) m_ad = m_q.pop_front();
        if (wr) begin
            w = -1;
            for (int k = 1; k <= N; k++)
                if (w < 0 && elig[(m_last + k) % N]) w = (m_last + k) % N;
            m_grant = '0;
            m_grant[w] = 1'b1;
            m_we   = 1;
            m_din  = bus.req_data[w*W +: W];
            m_q.push_back(m_din);
            m_last = w;
        end else begin
            m_grant = '0;
            m_we    = 0;
        end
        m_cnt = m_cnt + (wr ? 1 : 0) - (rd ? 1 : 0);
    endtask

    task automatic compare_all();
        chk("grant", 32'(bus.grant), 32'(m_grant));
        chk("fifo_we", 32'(bus.fifo_write_enable), 32'(m_we));
        if (m_we) chk("fifo_data_in", bus.fifo_data_in, m_din);
        chk("fifo_re", 32'(bus.fifo_read_enable), 32'(m_re));
        chk("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
        chk("rd_data", bus.rd_data, m_rd);
        chk("count", 32'(bus.count), 32'(m_cnt));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_data(input int i, input logic [W-1:0] v);
        bus.req_data[i*W +: W] = v;
    endtask

    // Assert reset between edges, check outputs clear immediately, release after one edge.
    task automatic async_reset_pulse();
        #3 reset = 1'b1;
        #1;
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_we", 32'(bus.fifo_write_enable), 32'h0);
        chk("rst_din", bus.fifo_data_in, 32'h0);
        chk("rst_re", 32'(bus.fifo_read_enable), 32'h0);
        chk("rst_rv", 32'(bus.rd_valid), 32'h0);
        chk("rst_rd_data", bus.rd_data, 32'h0);
        chk("rst_count", 32'(bus.count), 32'h0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic drain();
        bus.req = '0;
        bus.rd_req = 1'b1;
        repeat (D + 4) tick();
        bus.rd_req = 1'b0;
        repeat (3) tick();
        chk("drained_count", 32'(bus.count), 32'h0);
    endtask

    initial begin
        int nw;
        reset = 1'b1;
        bus.req = '0;
        bus.rd_req = 1'b0;
        bus.req_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        compare_all();

        // Async reset while writing; requester 0 wins first after release
        bus.req = 4'b1111;
        for (int i = 0; i < N; i++) set_data(i, 32'hA0 + 32'(i));
        repeat (3) tick();
        async_reset_pulse();
        tick();
        chk("first_grant_req0", 32'(bus.grant), 32'h1);
        chk("first_data", bus.fifo_data_in, 32'hA0);

        // All requesters: 1 write per cycle until full at 21
        repeat (23) tick();
        chk("full_count", 32'(bus.count), 32'd21);
        chk("full_no_grant", 32'(bus.grant), 32'h0);
        chk("full_no_we", 32'(bus.fifo_write_enable), 32'h0);
        drain();

        // Single requester 2: one word every other cycle
        bus.req = 4'b0100;
        set_data(2, 32'hC0DE0000);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (m_grant[2]) set_data(2, bus.req_data[2*W +: W] + 32'h1);
        end
        chk("single_req_count", 32'(bus.count), 32'd4);
        drain();

        // Write 11,22,33 then read them back to back; then rd_req on empty
        bus.req = 4'b0001;
        set_data(0, 32'h11);
        nw = 0;
        for (int i = 0; i < 10 && nw < 3; i++) begin
            tick();
            if (m_grant[0]) begin
                nw++;
                if (nw == 1) set_data(0, 32'h22);
                else if (nw == 2) set_data(0, 32'h33);
                else bus.req = '0;
            end
        end
        chk("three_written", 32'(bus.count), 32'd3);
        bus.rd_req = 1'b1;
        repeat (6) tick();
        chk("three_read_count", 32'(bus.count), 32'h0);
        chk("three_read_last", bus.rd_data, 32'h33);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("empty_no_re", 32'(bus.fifo_read_enable), 32'h0);
            chk("empty_no_rv", 32'(bus.rd_valid), 32'h0);
        end
        bus.rd_req = 1'b0;

        // Full boundary: read admitted with write blocked, write admitted next cycle
        bus.req = 4'b1111;
        for (int i = 0; i < N; i++) set_data(i, $urandom);
        repeat (23) tick();
        chk("refill_count", 32'(bus.count), 32'd21);
        bus.req = 4'b0010;
        bus.rd_req = 1'b1;
        tick();
        chk("bound_count", 32'(bus.count), 32'd20);
        chk("bound_re", 32'(bus.fifo_read_enable), 32'h1);
        chk("bound_we_blocked", 32'(bus.fifo_write_enable), 32'h0);
        bus.rd_req = 1'b0;
        tick();
        chk("bound_we_next", 32'(bus.fifo_write_enable), 32'h1);
        chk("bound_grant1", 32'(bus.grant), 32'h2);
        drain();

        // Random traffic with one mid-run reset
        for (int i = 0; i < 400; i++) begin
            bus.req = N'($urandom_range(0, 15));
            for (int r = 0; r < N; r++) set_data(r, $urandom);
            bus.rd_req = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if (i == 150) async_reset_pulse();
            else tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
